// File: rtl/seq_fsm_pkg.sv
// Shared types and reset-default tables for the programmable 4-state Moore FSM.
package seq_fsm_pkg;

  typedef enum logic [1:0] {A = 2'd0, B = 2'd1, C = 2'd2, D = 2'd3} state_t;

  // Entry index is {state, in_}; entry 15 is the leftmost element.
  localparam logic [15:0][1:0] DEFAULT_NEXT_TBL = {
    2'd3, 2'd0, 2'd1, 2'd2,   // D: 11->D 10->A 01->B 00->C
    2'd3, 2'd0, 2'd3, 2'd0,   // C: 11->D 10->A 01->D 00->A
    2'd3, 2'd0, 2'd1, 2'd2,   // B: 11->D 10->A 01->B 00->C
    2'd3, 2'd0, 2'd1, 2'd0    // A: 11->D 10->A 01->B 00->A
  };

  localparam logic [3:0] DEFAULT_OUT_TBL = 4'b1000;

endpackage

// File: rtl/seq_fsm_tbl.sv
// Writable next-state / output register file with lock gating and two
// combinational read ports.
module seq_fsm_tbl
  import seq_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  input  logic       wr_next_en,
  input  logic       wr_out_en,
  input  logic [1:0] wr_state,
  input  logic [1:0] wr_in,
  input  logic [1:0] wr_next,
  input  logic       wr_out,
  input  logic [1:0] rd_state,
  input  logic [1:0] rd_in,
  output logic [1:0] rd_next,
  output logic       rd_out
);

  logic [15:0][1:0] next_tbl;
  logic [3:0]       out_tbl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_tbl <= DEFAULT_NEXT_TBL;
      out_tbl  <= DEFAULT_OUT_TBL;
    end else begin
      if (wr_next_en && !locked) next_tbl[{wr_state, wr_in}] <= wr_next;
      if (wr_out_en && !locked)  out_tbl[wr_state]           <= wr_out;
    end
  end

  // Reads see the registered contents, so a same-cycle write lands only after the edge.
  assign rd_next = next_tbl[{rd_state, rd_in}];
  assign rd_out  = out_tbl[rd_state];

endmodule

// File: rtl/seq_fsm_4s2i1o_prog.sv
// Programmable 4-state, 2-input, 1-output Moore FSM with sticky config lock
// and a saturating state-change counter.
module seq_fsm_4s2i1o_prog
  import seq_fsm_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [1:0]       in_,
  input  logic             cfg_en,
  input  logic [1:0]       cfg_state,
  input  logic [1:0]       cfg_in,
  input  logic [1:0]       cfg_next,
  input  logic             cfg_out_en,
  input  logic             cfg_out,
  input  logic             cfg_lock,
  output logic             locked,
  output logic [1:0]       state,
  output logic             out,
  output logic [CNT_W-1:0] trans_cnt
);

  state_t     state_q, state_d;
  logic [1:0] tbl_next;

  seq_fsm_tbl u_tbl (
    .clk        (clk),
    .rst        (reset),
    .locked     (locked),
    .wr_next_en (cfg_en),
    .wr_out_en  (cfg_out_en),
    .wr_state   (cfg_state),
    .wr_in      (cfg_in),
    .wr_next    (cfg_next),
    .wr_out     (cfg_out),
    .rd_state   (state_q),
    .rd_in      (in_),
    .rd_next    (tbl_next),
    .rd_out     (out)
  );

  always_comb begin
    state_d = state_q;
    if (run) state_d = state_t'(tbl_next);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= A;
      locked    <= 1'b0;
      trans_cnt <= '0;
    end else begin
      state_q <= state_d;
      locked  <= locked | cfg_lock;
      if (state_d != state_q && trans_cnt != {CNT_W{1'b1}})
        trans_cnt <= trans_cnt + CNT_W'(1);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_seq_fsm_4s2i1o_prog.sv
// Directed bench: an 8-bit-counter instance plus a 3-bit-counter instance
// driven in parallel so saturation can be observed quickly.
module tb_seq_fsm_4s2i1o_prog;

  logic       clk = 1'b0;
  logic       reset, run, cfg_en, cfg_out_en, cfg_out, cfg_lock;
  logic [1:0] in_, cfg_state, cfg_in, cfg_next;
  logic       locked, out, locked3, out3;
  logic [1:0] state, state3;
  logic [7:0] trans_cnt;
  logic [2:0] trans_cnt3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_fsm_4s2i1o_prog #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset), .run(run), .in_(in_),
    .cfg_en(cfg_en), .cfg_state(cfg_state), .cfg_in(cfg_in), .cfg_next(cfg_next),
    .cfg_out_en(cfg_out_en), .cfg_out(cfg_out), .cfg_lock(cfg_lock),
    .locked(locked), .state(state), .out(out), .trans_cnt(trans_cnt)
  );

  seq_fsm_4s2i1o_prog #(.CNT_W(3)) dut3 (
    .clk(clk), .reset(reset), .run(run), .in_(in_),
    .cfg_en(cfg_en), .cfg_state(cfg_state), .cfg_in(cfg_in), .cfg_next(cfg_next),
    .cfg_out_en(cfg_out_en), .cfg_out(cfg_out), .cfg_lock(cfg_lock),
    .locked(locked3), .state(state3), .out(out3), .trans_cnt(trans_cnt3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cfg();
    cfg_en = 0; cfg_out_en = 0; cfg_lock = 0;
    cfg_state = 0; cfg_in = 0; cfg_next = 0; cfg_out = 0;
  endtask

  task automatic test_reset();
    idle_cfg();
    run = 0; in_ = 0;
    reset = 1;
    step();
    step();
    checks++;
    if (state !== 2'd0 || out !== 1'b0 || locked !== 1'b0 || trans_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset: state=%0d out=%b locked=%b cnt=%0d, want 0 0 0 0",
               state, out, locked, trans_cnt);
    end
    reset = 0;
    step();
    checks++;
    if (state !== 2'd0 || trans_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_release: state=%0d cnt=%0d, want 0 0", state, trans_cnt);
    end
  endtask

  // Default-table walk from A; leaves the FSM in C with 7 transitions counted.
  task automatic run_default_seq(input string tag);
    logic [1:0] ins   [9] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
    logic [1:0] exp_s [9] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
    run = 1;
    for (int i = 0; i < 9; i++) begin
      in_ = ins[i];
      step();
      checks++;
      if (state !== exp_s[i] || out !== (exp_s[i] == 2'd3)) begin
        errors++;
        $display("FAIL %s step %0d: state=%0d out=%b, want state=%0d out=%b",
                 tag, i, state, out, exp_s[i], (exp_s[i] == 2'd3));
      end
    end
    checks++;
    if (trans_cnt !== 8'd7 || trans_cnt3 !== 3'd7) begin
      errors++;
      $display("FAIL %s cnt: cnt=%0d cnt3=%0d, want 7 7", tag, trans_cnt, trans_cnt3);
    end
  endtask

  task automatic test_defaults();
    run_default_seq("defaults");
  endtask

  task automatic test_run_gating();
    run = 1; in_ = 2'd1;
    step();                       // C -01-> D
    step();                       // D -01-> B
    checks++;
    if (state !== 2'd1 || trans_cnt !== 8'd9) begin
      errors++;
      $display("FAIL gate_setup: state=%0d cnt=%0d, want 1 9", state, trans_cnt);
    end
    run = 0; in_ = 2'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (state !== 2'd1 || trans_cnt !== 8'd9) begin
        errors++;
        $display("FAIL gate_hold %0d: state=%0d cnt=%0d, want 1 9", i, state, trans_cnt);
      end
    end
    run = 1;
    step();
    checks++;
    if (state !== 2'd2 || trans_cnt !== 8'd10) begin
      errors++;
      $display("FAIL gate_resume: state=%0d cnt=%0d, want 2 10", state, trans_cnt);
    end
  endtask

  task automatic test_reprogram();
    run = 1; in_ = 2'd0;
    step();                       // C -00-> A, cnt 11
    run = 0;
    cfg_en = 1; cfg_state = 2'd0; cfg_in = 2'd0; cfg_next = 2'd3;
    cfg_out_en = 1; cfg_out = 1;
    step();
    idle_cfg();
    checks++;
    if (state !== 2'd0 || out !== 1'b1) begin
      errors++;
      $display("FAIL out_write: state=%0d out=%b, want 0 1", state, out);
    end
    run = 1; in_ = 2'd0;
    step();
    checks++;
    if (state !== 2'd3 || trans_cnt !== 8'd12) begin
      errors++;
      $display("FAIL next_write: state=%0d cnt=%0d, want 3 12", state, trans_cnt);
    end
    in_ = 2'd2;
    step();                       // D -10-> A, cnt 13
    in_ = 2'd1;
    cfg_en = 1; cfg_state = 2'd0; cfg_in = 2'd1; cfg_next = 2'd2;
    step();
    idle_cfg();
    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("FAIL rbw_old: state=%0d, want 1", state);
    end
    in_ = 2'd2;
    step();                       // B -10-> A
    in_ = 2'd1;
    step();
    checks++;
    if (state !== 2'd2 || trans_cnt !== 8'd16) begin
      errors++;
      $display("FAIL rbw_new: state=%0d cnt=%0d, want 2 16", state, trans_cnt);
    end
  endtask

  task automatic test_lock();
    run = 1; in_ = 2'd1;
    step();                       // C -01-> D
    step();                       // D -01-> B, cnt 18
    run = 0;
    cfg_lock = 1; cfg_en = 1; cfg_state = 2'd1; cfg_in = 2'd1; cfg_next = 2'd0;
    step();
    idle_cfg();
    checks++;
    if (locked !== 1'b1 || state !== 2'd1) begin
      errors++;
      $display("FAIL lock_set: locked=%b state=%0d, want 1 1", locked, state);
    end
    cfg_en = 1; cfg_state = 2'd1; cfg_in = 2'd1; cfg_next = 2'd3;
    cfg_out_en = 1; cfg_out = 0;
    cfg_state = 2'd1;
    step();
    cfg_out_en = 1; cfg_state = 2'd0; cfg_out = 0; cfg_en = 0;
    step();
    idle_cfg();
    run = 1; in_ = 2'd1;
    step();
    checks++;
    if (state !== 2'd0 || locked !== 1'b1 || trans_cnt !== 8'd19) begin
      errors++;
      $display("FAIL lock_ignore: state=%0d locked=%b cnt=%0d, want 0 1 19",
               state, locked, trans_cnt);
    end
    checks++;
    if (out !== 1'b1) begin
      errors++;
      $display("FAIL lock_out_hold: out=%b, want 1", out);
    end
  endtask

  task automatic test_reset_mid();
    run = 1; in_ = 2'd2;
    step();                       // A -10-> A
    in_ = 2'd0;
    step();                       // A -00-> D (reprogrammed entry)
    reset = 1;
    #2;
    reset = 0;
    #1;
    checks++;
    if (state !== 2'd0 || out !== 1'b0 || locked !== 1'b0 || trans_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid: state=%0d out=%b locked=%b cnt=%0d, want 0 0 0 0",
               state, out, locked, trans_cnt);
    end
    run_default_seq("after_reset");
  endtask

  task automatic test_saturation();
    reset = 1; #2; reset = 0;
    run = 1;
    for (int i = 0; i < 10; i++) begin
      in_ = (i % 2 == 0) ? 2'd1 : 2'd2;
      step();
      if (i == 6) begin
        checks++;
        if (trans_cnt3 !== 3'd7) begin
          errors++;
          $display("FAIL sat_reach: cnt3=%0d, want 7", trans_cnt3);
        end
      end
    end
    checks++;
    if (trans_cnt3 !== 3'd7 || trans_cnt !== 8'd10 || state3 !== 2'd0) begin
      errors++;
      $display("FAIL sat_hold: cnt3=%0d cnt=%0d state3=%0d, want 7 10 0",
               trans_cnt3, trans_cnt, state3);
    end
  endtask

  initial begin
    reset = 1; run = 0; in_ = 0;
    idle_cfg();
    #1;
    test_reset();
    test_defaults();
    test_run_gating();
    test_reprogram();
    test_lock();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
